// File: rtl/alu_pkg.sv
// Definitions shared by the ALU execution units: op encodings and the default datapath width.
package alu_pkg;

  localparam int unsigned OP_WIDTH           = 3;
  localparam int unsigned DATA_WIDTH_DEFAULT = 16;

  localparam logic [OP_WIDTH-1:0] OP_AND  = 3'b000;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 3'b001;
  localparam logic [OP_WIDTH-1:0] OP_NAND = 3'b010;
  localparam logic [OP_WIDTH-1:0] OP_NOR  = 3'b011;
  localparam logic [OP_WIDTH-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_WIDTH-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 3'b110;
  localparam logic [OP_WIDTH-1:0] OP_SHR  = 3'b111;

endpackage

// File: rtl/logic_pipe_reg.sv
// One pipeline stage of the logic/shift unit: {valid, zero, data} register with load enable.
module logic_pipe_reg #(
  parameter int unsigned WIDTH = 18
) (
  input  logic             clk,
  input  logic             async_rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/logic_shift_pipe.sv
// Pipelined logic/shift unit of the ALU with valid/ready handshakes and a registered zero flag.
module logic_shift_pipe #(
  parameter int unsigned DATA_WIDTH  = alu_pkg::DATA_WIDTH_DEFAULT,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned OP_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [OP_WIDTH-1:0]   op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero_flag
);
  import alu_pkg::*;

  localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);
  localparam int unsigned RegW        = DATA_WIDTH + 2;

  if (OP_WIDTH != 3) begin : g_bad_op_width
    $error("logic_shift_pipe: OP_WIDTH must be 3");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("logic_shift_pipe: PIPE_STAGES must be 1..4");
  end
  if (DATA_WIDTH < 4 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $error("logic_shift_pipe: DATA_WIDTH must be a power of 2 and >= 4");
  end

  logic                   adv;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  op_res;
  logic [RegW-1:0]        stage [PIPE_STAGES+1];

  // Upper B bits are ignored, so a shift by DATA_WIDTH wraps to a shift by 0.
  assign shamt = B[SHAMT_WIDTH-1:0];

  always_comb begin
    op_res = '0;
    case (op)
      OP_AND:  op_res = A & B;
      OP_OR:   op_res = A | B;
      OP_NAND: op_res = ~(A & B);
      OP_NOR:  op_res = ~(A | B);
      OP_XOR:  op_res = A ^ B;
      OP_XNOR: op_res = ~(A ^ B);
      OP_SHL:  op_res = A << shamt;
      OP_SHR:  op_res = A >> shamt;
      default: op_res = '0;
    endcase
  end

  // Single global stall: the whole pipe moves only when the output slot is free or draining.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  assign stage[0] = {in_valid, ~|op_res, op_res};

  for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
    logic_pipe_reg #(
      .WIDTH (RegW)
    ) u_stage (
      .clk       (clk),
      .async_rst (async_rst),
      .en_i      (adv),
      .d_i       (stage[g]),
      .q_o       (stage[g+1])
    );
  end

  assign out_valid = stage[PIPE_STAGES][RegW-1];
  assign zero_flag = stage[PIPE_STAGES][DATA_WIDTH];
  assign result    = stage[PIPE_STAGES][DATA_WIDTH-1:0];

endmodule

// File: tb/tb_logic_shift_pipe.sv
// Directed bench for logic_shift_pipe: three builds (1, 2 and 4 stages) share one input stream.
module tb_logic_shift_pipe;

  logic        clk = 1'b0;
  logic        async_rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  op;

  logic [2:0]  in_ready_w;
  logic [2:0]  out_valid_w;
  logic [2:0]  zero_w;
  logic [15:0] res_w [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logic_shift_pipe #(.DATA_WIDTH(16), .PIPE_STAGES(1), .OP_WIDTH(3)) dut1 (
    .clk(clk), .async_rst(async_rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .A(a), .B(b), .op(op), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .result(res_w[0]), .zero_flag(zero_w[0])
  );
  logic_shift_pipe #(.DATA_WIDTH(16), .PIPE_STAGES(2), .OP_WIDTH(3)) dut2 (
    .clk(clk), .async_rst(async_rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .A(a), .B(b), .op(op), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .result(res_w[1]), .zero_flag(zero_w[1])
  );
  logic_shift_pipe #(.DATA_WIDTH(16), .PIPE_STAGES(4), .OP_WIDTH(3)) dut4 (
    .clk(clk), .async_rst(async_rst), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .A(a), .B(b), .op(op), .out_valid(out_valid_w[2]), .out_ready(out_ready),
    .result(res_w[2]), .zero_flag(zero_w[2])
  );

  // Cycles from accept edge to output, per build.
  int lat [3] = '{0, 1, 3};

  localparam int NV = 13;
  logic [2:0]  vop [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6, 3'd6,
                            3'd0, 3'd1, 3'd7};
  logic [15:0] va  [NV] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0,
                            16'h8001, 16'h8001, 16'h8001, 16'h0001, 16'h00FF, 16'h00FF,
                            16'h8001};
  logic [15:0] vb  [NV] = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00,
                            16'h0004, 16'h0004, 16'h0010, 16'h000F, 16'hFF00, 16'hFF00,
                            16'h0010};
  logic [15:0] vexp[NV] = '{16'hF000, 16'hFFF0, 16'h0FFF, 16'h000F, 16'h0FF0, 16'hF00F,
                            16'h0010, 16'h0800, 16'h8001, 16'h8000, 16'h0000, 16'hFFFF,
                            16'h8001};
  logic        vzero[NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          sent;
    int          got;
    logic [15:0] held;

    async_rst = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    op = '0;

    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst d%0d valid", d), out_valid_w[d], 1'b0);
      chk($sformatf("rst d%0d result", d), res_w[d], 16'h0000);
      chk($sformatf("rst d%0d zero", d), zero_w[d], 1'b0);
      chk($sformatf("rst d%0d in_ready", d), in_ready_w[d], 1'b1);
    end
    @(negedge clk);
    async_rst = 1'b1;
    tick();

    // Op sweep, shifts and zero flag streamed back to back; each build checked at its latency.
    for (int i = 0; i < NV + 4; i++) begin
      in_valid = (i < NV);
      if (i < NV) begin
        op = vop[i];
        a  = va[i];
        b  = vb[i];
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        int k;
        k = i - lat[d];
        if (k >= 0 && k < NV) begin
          chk($sformatf("sweep d%0d b%0d valid", d, k), out_valid_w[d], 1'b1);
          chk($sformatf("sweep d%0d b%0d result", d, k), res_w[d], vexp[k]);
          chk($sformatf("sweep d%0d b%0d zero", d, k), zero_w[d], vzero[k]);
        end else begin
          chk($sformatf("sweep d%0d c%0d idle", d, i), out_valid_w[d], 1'b0);
        end
      end
    end

    // Backpressure on the 2-stage build: 5 beats, out_ready low for cycles 3..5.
    sent = 0;
    got  = 0;
    held = '0;
    op   = 3'b001;
    b    = 16'h0000;
    for (int c = 0; c < 30 && got < 5; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 5);
      a         = 16'(16'h1111 * (sent + 1));
      #1;
      if (!out_ready) begin
        chk($sformatf("bp c%0d in_ready", c), in_ready_w[1], 1'b0);
        chk($sformatf("bp c%0d valid", c), out_valid_w[1], 1'b1);
        if (c == 3) held = res_w[1];
        else chk($sformatf("bp c%0d hold", c), res_w[1], held);
      end else if (out_valid_w[1]) begin
        chk($sformatf("bp beat%0d", got), res_w[1], 16'(16'h1111 * (got + 1)));
        got++;
      end
      if (in_valid && in_ready_w[1]) sent++;
      tick();
    end
    chk("bp delivered", got, 5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp no duplicate", out_valid_w[1], 1'b0);
    for (int i = 0; i < 4; i++) tick();

    // Reset with two beats in flight.
    in_valid = 1'b1;
    op = 3'b001;
    a  = 16'h00F0;
    b  = 16'h0F00;
    tick();
    op = 3'b000;
    a  = 16'h00FF;
    b  = 16'hFF00;
    tick();
    in_valid = 1'b0;
    chk("pre-rst valid", out_valid_w[1], 1'b1);
    chk("pre-rst result", res_w[1], 16'h0FF0);
    #2;
    async_rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst d%0d valid", d), out_valid_w[d], 1'b0);
      chk($sformatf("midrst d%0d result", d), res_w[d], 16'h0000);
      chk($sformatf("midrst d%0d zero", d), zero_w[d], 1'b0);
      chk($sformatf("midrst d%0d in_ready", d), in_ready_w[d], 1'b1);
    end
    @(posedge clk);
    @(negedge clk);
    async_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 3; d++)
        chk($sformatf("postrst d%0d c%0d idle", d, i), out_valid_w[d], 1'b0);
    end
    in_valid = 1'b1;
    op = 3'b100;
    a  = 16'h1234;
    b  = 16'h00FF;
    tick();
    in_valid = 1'b0;
    chk("postrst d1 valid", out_valid_w[0], 1'b1);
    chk("postrst d1 result", res_w[0], 16'h12CB);
    chk("postrst d2 not yet", out_valid_w[1], 1'b0);
    tick();
    chk("postrst d2 valid", out_valid_w[1], 1'b1);
    chk("postrst d2 result", res_w[1], 16'h12CB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
